mem_burst_master: RTL and testbench
===================================

# mem_burst_master

Bus master for the 64x8 single-port synchronous scratch memory (chip-select, write-enable, 6-bit address, 8-bit data in and out). It takes burst requests from the processor datapath or a loader and turns them into one memory command per cycle. Address increments modulo 64. Write data arrives on a valid/ready stream. Read data is returned on a valid-only stream with a last flag. It owns the memory's control pins exclusively and sits between the requester and the memory instance.

## Interface
Parameters:
- ADDR_W, 6, memory address width; depth is 2^ADDR_W
- DATA_W, 8, memory data width
- LEN_W, 6, burst length field width; req_len encodes beats-1, so 1..64 beats

Ports:
- clock  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write burst, 0 = read burst
- req_adr  in  ADDR_W  start address
- req_len  in  LEN_W  beats minus one
- wdata_valid  in  1  write beat available
- wdata  in  DATA_W  write beat
- wdata_ready  out  1  write beat consumed this cycle
- rdata_valid  out  1  read beat valid; no backpressure
- rdata  out  DATA_W  read beat
- rdata_last  out  1  final beat of the read burst
- busy  out  1  state != IDLE
- done  out  1  one-cycle burst-complete pulse
- mem_cs, mem_wr  out  1  memory chip-select and write-enable (registered)
- mem_adr  out  ADDR_W  memory address (registered)
- mem_din  out  DATA_W  memory write data (registered)
- mem_dout  in  DATA_W  memory read data; valid only in the cycle after the memory's read edge, otherwise high-Z

## Operation
- States: IDLE, WR, RD, RD_TAIL.
- IDLE: req_ready=1.
  - Handshake on req_valid & req_ready.
  - Latch adr_q=req_adr and cnt_q=req_len.
  - Go to WR if req_wr, else RD.
- WR:
  - wdata_ready = wdata_valid (combinational).
  - Each accepted beat registers mem_cs=1, mem_wr=1, mem_adr=adr_q, mem_din=wdata.
  - Then adr_q+1 (wraps 63->0) and cnt_q-1.
  - Cycles without wdata_valid register mem_cs=0: a bubble, with no address advance.
  - When the beat with cnt_q==0 is accepted, go to IDLE.
- RD:
  - Every cycle registers mem_cs=1, mem_wr=0, mem_adr=adr_q.
  - Then adr_q+1 (wrap) and cnt_q-1.
  - When the cnt_q==0 beat is issued, go to RD_TAIL.
- RD_TAIL:
  - Waits for the two in-flight read beats to return.
  - Uses a 2-bit pipeline tag shift register, one tag per issued read.
  - Go to IDLE in the cycle the last tag retires.
- Read return: a 2-stage valid/last shift register tracks issued reads. mem_dout is registered into rdata exactly in the cycle the tag is in stage 1. Never sample mem_dout otherwise.
- Outside WR/RD issue cycles, mem_cs=0, mem_wr=0. mem_adr and mem_din hold their last values.
- Address arithmetic is ADDR_W bits, unsigned, and wraps silently. A 64-beat burst touches every location exactly once.
- Reset (any state): all outputs 0 next cycle, pending read tags cleared, FSM to IDLE. No rdata_valid or done may follow a reset.

## Timing
- Command registered at edge E0 is visible in cycle C0. The memory samples at the end of C0, and mem_dout is valid in C1. The master captures at the end of C1, so rdata_valid is high in C2.
- Read latency: request handshake cycle to first rdata_valid is 3 cycles. Beats then follow back to back, one per cycle.
- A read burst of N beats gives N consecutive rdata_valid cycles. rdata_last is set on the Nth.
- Read done: asserted in the same cycle as rdata_last. busy drops in that cycle, req_ready=1, and a new request may be accepted in that same cycle.
- Write done: asserted one cycle after the cycle in which the last write command is visible on mem_*. The FSM is already IDLE in that cycle, so back-to-back bursts are allowed.
- Write throughput: one beat per cycle while wdata_valid is held high.

## Structure
- Shared package mem_bus_pkg:
  - state enum {IDLE, WR, RD, RD_TAIL}
  - MEM_ADDR_W=6, MEM_DATA_W=8, MEM_DEPTH=64, READ_LAT=2
- Single module, no sub-module. The 64x8 memory is instantiated next to it at top level and in the bench, not inside this block.

## Test plan
- Write burst adr=60, len=7 (8 beats), data 0xA0..0xA7 with wdata_valid continuous. Then read burst adr=60, len=7. Required: mem locations 60..63,0..3 = A0..A7; rdata sequence A0..A7; rdata_last on beat 8; first rdata_valid 3 cycles after the handshake.
- Write 4 beats to adr=10 with wdata_valid low every other cycle. Required: mem_cs bubbles in gap cycles, no address skip, locations 10..13 correct, done once.
- Full 64-beat read from adr=0 after filling mem[i]=i. Required: 64 contiguous rdata_valid, values 0x00..0x3F, adr wraps back to 0.
- Single-beat read (len=0) at adr=5 immediately followed by a write request accepted in the done cycle. Required: rdata=mem[5] with rdata_last=done=1, then the write starts on the next cycle.
- Reset asserted in RD_TAIL with 2 beats in flight. Required: no rdata_valid or done afterward, all outputs 0, req_ready=1 one cycle after reset.
- Reset during WR mid-burst. Required: mem_cs=0 next cycle, remaining locations unchanged.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the scratch-memory bus master and its neighbours.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 64;
  localparam int READ_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_TAIL = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Burst master for the 64x8 scratch memory: turns burst requests into one
// registered memory command per cycle and returns read data with a last flag.
module mem_burst_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = $clog2(MEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e              state_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [READ_LAT-1:0] tag_valid;
  logic [READ_LAT-1:0] tag_last;
  logic                wr_done_q;

  logic wr_beat;
  logic rd_beat;
  logic last_beat;
  logic rd_retire_last;

  assign wr_beat        = (state_q == WR) && wdata_valid;
  assign rd_beat        = (state_q == RD);
  assign last_beat      = (cnt_q == '0);
  assign rd_retire_last = tag_valid[READ_LAT-1] && tag_last[READ_LAT-1];

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wdata_ready = wr_beat;

  // Tag stage 0 is the cycle a read command sits on the bus; the top stage is
  // the single cycle mem_dout is driven, so it is the only time it is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      cnt_q       <= '0;
      tag_valid   <= '0;
      tag_last    <= '0;
      wr_done_q   <= 1'b0;
      mem_cs      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_adr     <= '0;
      mem_din     <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_cs <= wr_beat || rd_beat;
      mem_wr <= wr_beat;
      if (wr_beat || rd_beat) begin
        mem_adr <= adr_q;
        adr_q   <= adr_q + ADDR_W'(1);
        cnt_q   <= cnt_q - LEN_W'(1);
      end
      if (wr_beat) begin
        mem_din <= wdata;
      end

      tag_valid <= {tag_valid[READ_LAT-2:0], rd_beat};
      tag_last  <= {tag_last[READ_LAT-2:0], rd_beat && last_beat};

      rdata_valid <= tag_valid[READ_LAT-1];
      rdata_last  <= rd_retire_last;
      if (tag_valid[READ_LAT-1]) begin
        rdata <= mem_dout;
      end

      // Write completion trails the last bus command by one cycle.
      wr_done_q <= wr_beat && last_beat;
      done      <= wr_done_q || rd_retire_last;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            adr_q   <= req_adr;
            cnt_q   <= req_len;
            state_q <= req_wr ? WR : RD;
          end
        end
        WR: begin
          if (wr_beat && last_beat) begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (last_beat) begin
            state_q <= RD_TAIL;
          end
        end
        RD_TAIL: begin
          if (rd_retire_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a behavioural 64x8 memory beside it.
module tb_mem_burst_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [5:0] req_adr;
  logic [5:0] req_len;
  logic       wdata_valid;
  logic [7:0] wdata;
  logic       wdata_ready;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       rdata_last;
  logic       busy;
  logic       done;
  logic       mem_cs;
  logic       mem_wr;
  logic [5:0] mem_adr;
  logic [7:0] mem_din;
  wire  [7:0] mem_dout;

  mem_burst_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_adr(req_adr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .busy(busy), .done(done),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_adr(mem_adr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  // Memory drives its output only in the cycle after a read edge.
  logic [7:0] mem [64];
  logic       mem_init;
  logic       mem_rd_q = 1'b0;
  logic [7:0] mem_rd_data = 8'h00;
  always @(posedge clock) begin
    mem_rd_q <= mem_cs & ~mem_wr;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
    end else begin
      if (mem_cs && !mem_wr) mem_rd_data <= mem[mem_adr];
      if (mem_cs && mem_wr) mem[mem_adr] <= mem_din;
    end
  end
  assign mem_dout = mem_rd_q ? mem_rd_data : 8'hzz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_edge = 0;
  logic [7:0]  ref_mem [64];
  logic [8:0]  rd_q [$];
  logic [13:0] wr_q [$];
  logic [5:0]  rd_adr_q [$];
  int valid_cyc_q [$];
  int done_cyc_q [$];
  int wr_cyc_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic [8:0]  r;
    logic [13:0] w;
    if (rdata_valid) begin
      valid_cyc_q.push_back(cyc);
      if (rd_q.size() == 0) check_output("unexpected_rdata", 1, 0);
      else begin
        r = rd_q.pop_front();
        check_output("rdata", 32'(rdata), 32'(r[7:0]));
        check_output("rdata_last", 32'(rdata_last), 32'(r[8]));
      end
    end
    if (done) done_cyc_q.push_back(cyc);
    if (mem_cs && mem_wr) begin
      wr_cyc_q.push_back(cyc);
      if (wr_q.size() == 0) check_output("unexpected_write", 1, 0);
      else begin
        w = wr_q.pop_front();
        check_output("wr_adr", 32'(mem_adr), 32'(w[13:8]));
        check_output("wr_din", 32'(mem_din), 32'(w[7:0]));
      end
    end
    if (mem_cs && !mem_wr) begin
      if (rd_adr_q.size() == 0) check_output("unexpected_read", 1, 0);
      else check_output("rd_adr", 32'(mem_adr), 32'(rd_adr_q.pop_front()));
    end
  end

  task automatic issue_request(input logic wr, input logic [5:0] adr, input logic [5:0] len);
    int t = 0;
    req_valid = 1'b1; req_wr = wr; req_adr = adr; req_len = len;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      t++;
      if (t > 50) begin
        check_output("req_timeout", 0, 1);
        break;
      end
    end
    hs_edge = cyc + 1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cyc_q.size() < n && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 300) check_output("done_timeout", 0, 1);
  endtask

  task automatic apply_stimulus_write(input logic [5:0] adr, input logic [5:0] len,
                                      input logic [7:0] base, input bit gaps);
    int n = int'(len) + 1;
    int beat = 0;
    int t = 0;
    int last_acc = 0;
    logic [5:0] a;
    wr_cyc_q.delete();
    done_cyc_q.delete();
    issue_request(1'b1, adr, len);
    while (beat < n && t < 400) begin
      wdata_valid = gaps ? (t % 2 == 0) : 1'b1;
      wdata = base + 8'(beat);
      @(negedge clock);
      if (wdata_ready) begin
        a = adr + 6'(beat);
        wr_q.push_back({a, wdata});
        ref_mem[a] = wdata;
        last_acc = cyc;
        beat++;
      end
      @(posedge clock); #1;
      t++;
    end
    wdata_valid = 1'b0;
    check_output("wr_beats", beat, n);
    wait_done(1);
    check_output("wr_done_count", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) check_output("wr_done_lat", done_cyc_q[0] - last_acc, 2);
    check_output("wr_q_drained", wr_q.size(), 0);
  endtask

  task automatic apply_stimulus_read(input logic [5:0] adr, input logic [5:0] len);
    int n = int'(len) + 1;
    logic [5:0] a;
    for (int i = 0; i < n; i++) begin
      a = adr + 6'(i);
      rd_q.push_back({(i == n - 1), ref_mem[a]});
      rd_adr_q.push_back(a);
    end
    valid_cyc_q.delete();
    done_cyc_q.delete();
    issue_request(1'b0, adr, len);
    wait_done(1);
    check_output("rd_beats", valid_cyc_q.size(), n);
    check_output("rd_done_count", done_cyc_q.size(), 1);
    if (valid_cyc_q.size() == n) begin
      check_output("rd_latency", valid_cyc_q[0] - hs_edge, 3);
      check_output("rd_contiguous", valid_cyc_q[n-1] - valid_cyc_q[0], n - 1);
      if (done_cyc_q.size() > 0) check_output("rd_done_with_last", done_cyc_q[0], valid_cyc_q[n-1]);
    end
    check_output("rd_q_drained", rd_q.size(), 0);
    check_output("rd_adr_drained", rd_adr_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int beat;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_adr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'hFF;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; mem_init = 1'b0;
    @(negedge clock);
    check_output("rst_req_ready", 32'(req_ready), 1);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_mem_cs", 32'(mem_cs), 0);
    check_output("rst_rdata_valid", 32'(rdata_valid), 0);
    check_output("rst_done", 32'(done), 0);
    @(posedge clock); #1;

    $display("[TB] wrapping write/read burst at 60");
    apply_stimulus_write(6'd60, 6'd7, 8'hA0, 1'b0);
    for (int i = 1; i < 8 && i < wr_cyc_q.size(); i++)
      check_output("wr_back_to_back", wr_cyc_q[i] - wr_cyc_q[i-1], 1);
    for (int i = 0; i < 8; i++)
      check_output("mem_wrap_wr", 32'(mem[6'(60 + i)]), 32'(8'hA0 + 8'(i)));
    apply_stimulus_read(6'd60, 6'd7);

    $display("[TB] gapped write to 10");
    apply_stimulus_write(6'd10, 6'd3, 8'h30, 1'b1);
    check_output("gap_wr_count", wr_cyc_q.size(), 4);
    for (int i = 1; i < 4 && i < wr_cyc_q.size(); i++)
      check_output("gap_bubble", wr_cyc_q[i] - wr_cyc_q[i-1], 2);
    for (int i = 0; i < 4; i++)
      check_output("mem_gap_wr", 32'(mem[10 + i]), 32'(8'h30 + 8'(i)));

    $display("[TB] full fill and 64-beat read");
    apply_stimulus_write(6'd0, 6'd63, 8'h00, 1'b0);
    for (int i = 0; i < 64; i++) check_output("mem_fill", 32'(mem[i]), i);
    apply_stimulus_read(6'd0, 6'd63);

    $display("[TB] single read then write in done cycle");
    rd_q.push_back({1'b1, ref_mem[5]});
    rd_adr_q.push_back(6'd5);
    valid_cyc_q.delete();
    done_cyc_q.delete();
    issue_request(1'b0, 6'd5, 6'd0);
    req_valid = 1'b1; req_wr = 1'b1; req_adr = 6'd30; req_len = 6'd0;
    wdata_valid = 1'b1; wdata = 8'hEE;
    beat = 0;
    do begin
      @(negedge clock);
      beat++;
    end while (!req_ready && beat < 20);
    check_output("single_done", 32'(done), 1);
    check_output("single_last", 32'(rdata_last), 1);
    check_output("single_rdata", 32'(rdata), 32'h05);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check_output("next_wr_busy", 32'(busy), 1);
    check_output("next_wr_ready", 32'(wdata_ready), 1);
    wr_q.push_back({6'd30, 8'hEE});
    ref_mem[30] = 8'hEE;
    beat = cyc;
    @(posedge clock); #1;
    wdata_valid = 1'b0;
    wait_done(2);
    check_output("single_done_count", done_cyc_q.size(), 2);
    if (done_cyc_q.size() > 1) check_output("next_wr_done_lat", done_cyc_q[1] - beat, 2);
    check_output("mem_30", 32'(mem[30]), 32'hEE);

    $display("[TB] reset during RD_TAIL");
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back({(i == 3), ref_mem[20 + i]});
      rd_adr_q.push_back(6'(20 + i));
    end
    issue_request(1'b0, 6'd20, 6'd3);
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_output("in_flight_beats", rd_q.size(), 2);
    rd_q.delete();
    valid_cyc_q.delete();
    done_cyc_q.delete();
    @(negedge clock);
    check_output("rt_req_ready", 32'(req_ready), 1);
    check_output("rt_outputs_zero",
                 {busy, done, rdata_valid, rdata_last, mem_cs, mem_wr, wdata_ready, rdata, mem_adr, mem_din}, 0);
    repeat (10) begin @(posedge clock); #1; end
    check_output("rt_no_valid", valid_cyc_q.size(), 0);
    check_output("rt_no_done", done_cyc_q.size(), 0);
    check_output("rt_rd_adr_drained", rd_adr_q.size(), 0);

    $display("[TB] reset during write burst");
    done_cyc_q.delete();
    issue_request(1'b1, 6'd40, 6'd7);
    beat = 0;
    for (int t = 0; t < 20 && beat < 3; t++) begin
      wdata_valid = 1'b1;
      wdata = 8'h50 + 8'(beat);
      @(negedge clock);
      if (wdata_ready) begin
        wr_q.push_back({6'(40 + beat), wdata});
        ref_mem[40 + beat] = wdata;
        beat++;
      end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    wdata = 8'h53;
    @(posedge clock); #1;
    reset = 1'b0;
    wdata_valid = 1'b0;
    @(negedge clock);
    check_output("rw_mem_cs", 32'(mem_cs), 0);
    check_output("rw_busy", 32'(busy), 0);
    repeat (5) begin @(posedge clock); #1; end
    check_output("rw_wr_q_drained", wr_q.size(), 0);
    check_output("rw_no_done", done_cyc_q.size(), 0);
    for (int i = 0; i < 3; i++) check_output("rw_written", 32'(mem[40 + i]), 32'(8'h50 + 8'(i)));
    for (int i = 3; i < 8; i++) check_output("rw_untouched", 32'(mem[40 + i]), 40 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
